// File: rtl/keypad_encoder_if.sv
// Keypad-side and event-side signals of keypad_encoder.
// The encoder uses the master modport. The keypad or consumer side uses the slave modport.
interface keypad_encoder_if;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [8:0] key_bus;
    logic       eq_pulse;
    logic       clr_pulse;

    modport master (
        input  row_n,
        output col_n, key_bus, eq_pulse, clr_pulse
    );

    modport slave (
        output row_n,
        input  col_n, key_bus, eq_pulse, clr_pulse
    );
endinterface

// File: rtl/keypad_encoder.sv
// 4x4 keypad scanner with frame-level debounce.
// Each accepted press produces one single-cycle key_bus event, or an eq_pulse or clr_pulse strobe.
module keypad_encoder #(
    parameter int SCAN_DIV       = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             rst,
    keypad_encoder_if.master bus
);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DS_MAX    = DW'(DEBOUNCE_SCANS);

    typedef enum logic [2:0] {S_SCAN, S_DEBOUNCE, S_EMIT, S_HELD, S_RELEASE} state_t;

    logic [3:0]    r_row_s1, r_row_s2;
    logic [SW-1:0] r_slot;
    logic [1:0]    r_col;
    logic [3:0]    r_col_n;
    logic [1:0]    r_acc_cnt;
    logic [3:0]    r_acc_code;
    state_t        r_state;
    logic [DW-1:0] r_dcnt;
    logic [3:0]    r_code;
    logic [8:0]    r_key_bus;
    logic          r_eq, r_clr;

    logic          w_slot_last, w_frame_end;
    logic [1:0]    w_acc_cnt;
    logic [3:0]    w_acc_code;
    state_t        w_state_next;
    logic [DW-1:0] w_dcnt_next;
    logic [3:0]    w_code_next;
    logic [8:0]    w_key_bus;
    logic          w_eq, w_clr;

    assign w_slot_last = (r_slot == SLOT_LAST);
    assign w_frame_end = w_slot_last && (r_col == 2'd3);

    // The result for the current slot is folded into the accumulator.
    // At frame end, w_acc_* holds the result for the whole completed frame.
    always_comb begin
        w_acc_cnt  = r_acc_cnt;
        w_acc_code = r_acc_code;
        for (int unsigned r = 0; r < 4; r++) begin
            if (!r_row_s2[r]) begin
                if (w_acc_cnt != 2'd2) w_acc_cnt = w_acc_cnt + 2'd1;
                w_acc_code = {2'(r), r_col};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_s1   <= '1;
            r_row_s2   <= '1;
            r_slot     <= '0;
            r_col      <= '0;
            r_col_n    <= 4'b1110;
            r_acc_cnt  <= '0;
            r_acc_code <= '0;
        end else begin
            r_row_s1 <= bus.row_n;
            r_row_s2 <= r_row_s1;
            if (w_slot_last) begin
                r_slot  <= '0;
                r_col   <= r_col + 2'd1;
                r_col_n <= {r_col_n[2:0], r_col_n[3]};
                if (r_col == 2'd3) begin
                    r_acc_cnt  <= '0;
                    r_acc_code <= '0;
                end else begin
                    r_acc_cnt  <= w_acc_cnt;
                    r_acc_code <= w_acc_code;
                end
            end else begin
                r_slot <= r_slot + SW'(1);
            end
        end
    end

    // State register. The outputs are registered from the next state, so they line up with EMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_SCAN;
            r_dcnt    <= '0;
            r_code    <= '0;
            r_key_bus <= '0;
            r_eq      <= 1'b0;
            r_clr     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_dcnt    <= w_dcnt_next;
            r_code    <= w_code_next;
            r_key_bus <= w_key_bus;
            r_eq      <= w_eq;
            r_clr     <= w_clr;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_dcnt_next  = r_dcnt;
        w_code_next  = r_code;
        unique case (r_state)
            S_SCAN: if (w_frame_end && w_acc_cnt == 2'd1) begin
                w_code_next  = w_acc_code;
                w_dcnt_next  = DW'(1);
                w_state_next = (DEBOUNCE_SCANS <= 1) ? S_EMIT : S_DEBOUNCE;
            end
            S_DEBOUNCE: if (w_frame_end) begin
                if (w_acc_cnt == 2'd1 && w_acc_code == r_code) begin
                    w_dcnt_next = r_dcnt + DW'(1);
                    if (w_dcnt_next == DS_MAX) w_state_next = S_EMIT;
                end else begin
                    w_dcnt_next  = '0;
                    w_state_next = S_SCAN;
                end
            end
            S_EMIT: begin
                w_dcnt_next  = '0;
                w_state_next = S_HELD;
            end
            S_HELD: if (w_frame_end && w_acc_cnt == 2'd0) begin
                w_dcnt_next  = DW'(1);
                w_state_next = (DEBOUNCE_SCANS <= 1) ? S_SCAN : S_RELEASE;
            end
            S_RELEASE: if (w_frame_end) begin
                if (w_acc_cnt == 2'd0) begin
                    w_dcnt_next = r_dcnt + DW'(1);
                    if (w_dcnt_next == DS_MAX) begin
                        w_dcnt_next  = '0;
                        w_state_next = S_SCAN;
                    end
                end else begin
                    w_dcnt_next  = '0;
                    w_state_next = S_HELD;
                end
            end
            default: begin
                w_dcnt_next  = '0;
                w_state_next = S_SCAN;
            end
        endcase
    end

    always_comb begin
        w_key_bus = '0;
        w_eq      = 1'b0;
        w_clr     = 1'b0;
        if (w_state_next == S_EMIT) begin
            unique case (w_code_next)
                4'd0:  w_key_bus = 9'h101;
                4'd1:  w_key_bus = 9'h102;
                4'd2:  w_key_bus = 9'h103;
                4'd3:  w_key_bus = 9'h010;
                4'd4:  w_key_bus = 9'h104;
                4'd5:  w_key_bus = 9'h105;
                4'd6:  w_key_bus = 9'h106;
                4'd7:  w_key_bus = 9'h020;
                4'd8:  w_key_bus = 9'h107;
                4'd9:  w_key_bus = 9'h108;
                4'd10: w_key_bus = 9'h109;
                4'd11: w_key_bus = 9'h040;
                4'd12: w_clr     = 1'b1;
                4'd13: w_key_bus = 9'h100;
                4'd14: w_eq      = 1'b1;
                4'd15: w_key_bus = 9'h080;
                default: w_key_bus = '0;
            endcase
        end
    end

    assign bus.col_n     = r_col_n;
    assign bus.key_bus   = r_key_bus;
    assign bus.eq_pulse  = r_eq;
    assign bus.clr_pulse = r_clr;
endmodule
